// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU step controller: FSM state encoding and PC width.
// The divider width helper keeps a 1-bit counter when RATE_DIV is 1.
package cpu_ctrl_pkg;

  localparam int PC_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BREAK = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  function automatic int div_width(input int rate);
    return (rate > 1) ? $clog2(rate) : 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on a level input: rise_out is combinational on sig_in.
// One register of history; rise_out is high for the single clk where sig_in first reads 1.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise_out
);

  logic sig_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign rise_out = sig_in & ~sig_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Sequences the core's clock-enable: single-step, free-run, breakpoint and halt control.
// cpu_en is registered, one clk after the deciding edge; no backpressure, DONE is left only by reset.
module cpu_step_controller #(
  parameter int PC_W     = cpu_ctrl_pkg::PC_W,
  parameter int RATE_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_pb,
  input  logic             run_sw,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_instr,
  output logic             cpu_en,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retired_cnt
);

  import cpu_ctrl_pkg::*;

  localparam int               DIV_W    = div_width(RATE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);

  ctrl_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             skip_q, skip_d;
  logic             cpu_en_q, cpu_en_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic step_rise;
  logic tick;
  logic bp_hit;

  rise_detect u_step_rise (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (step_pb),
    .rise_out (step_rise)
  );

  assign tick   = (div_q == DIV_LAST);
  // skip lets the instruction parked on the breakpoint retire once before re-arming
  assign bp_hit = bp_en && (pc == bp_addr) && !skip_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    skip_d    = skip_q;
    cpu_en_d  = 1'b0;
    retired_d = retired_q;

    if (cpu_en_q && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (run_sw) begin
          state_d = RUN;
          div_d   = '0;
        end else if (step_rise) begin
          if (halt_instr) begin
            state_d = DONE;
          end else begin
            cpu_en_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (!run_sw) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (tick) begin
          div_d = '0;
          if (bp_hit) begin
            state_d = BREAK;
          end else if (halt_instr) begin
            state_d = DONE;
          end else begin
            cpu_en_d = 1'b1;
            skip_d   = 1'b0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      BREAK: begin
        if (step_rise) begin
          if (halt_instr) begin
            state_d = DONE;
          end else begin
            cpu_en_d = 1'b1;
            skip_d   = 1'b1;
            div_d    = '0;
            state_d  = run_sw ? RUN : IDLE;
          end
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      skip_q    <= 1'b0;
      cpu_en_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      skip_q    <= skip_d;
      cpu_en_q  <= cpu_en_d;
      retired_q <= retired_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign state_o     = state_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench: step, run, breakpoint, halt, reset and counter saturation on two instances.
module tb_cpu_step_controller;

  logic        clk;
  logic        reset;
  logic        step_pb;
  logic        run_sw;
  logic        bp_en;
  logic [8:0]  bp_addr;
  logic [8:0]  pc;
  logic        halt_arm;
  logic [8:0]  halt_pc;
  logic        halt_instr;
  logic        cpu_en;
  logic [1:0]  state_o;
  logic [15:0] retired_cnt;

  logic        sat_run;
  logic        zero_bit;
  logic [8:0]  zero_pc;
  logic        sat_cpu_en;
  logic [1:0]  sat_state;
  logic [3:0]  sat_cnt;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  cpu_step_controller #(.PC_W(9), .RATE_DIV(4), .CNT_W(16)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .step_pb     (step_pb),
    .run_sw      (run_sw),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .halt_instr  (halt_instr),
    .cpu_en      (cpu_en),
    .state_o     (state_o),
    .retired_cnt (retired_cnt)
  );

  cpu_step_controller #(.PC_W(9), .RATE_DIV(1), .CNT_W(4)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .step_pb     (zero_bit),
    .run_sw      (sat_run),
    .bp_en       (zero_bit),
    .bp_addr     (zero_pc),
    .pc          (zero_pc),
    .halt_instr  (zero_bit),
    .cpu_en      (sat_cpu_en),
    .state_o     (sat_state),
    .retired_cnt (sat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program-counter model: advances on each retired instruction.
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else if (cpu_en) pc <= pc + 9'd1;
  end

  assign halt_instr = halt_arm && (pc == halt_pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    step_pb  = 1'b0;
    run_sw   = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = '0;
    halt_arm = 1'b0;
    halt_pc  = '0;
    sat_run  = 1'b0;
    zero_bit = 1'b0;
    zero_pc  = '0;

    repeat (2) @(negedge clk);
    chk("reset_cpu_en", 32'(cpu_en), 32'(0));
    chk("reset_state", 32'(state_o), 32'(0));
    chk("reset_retired", 32'(retired_cnt), 32'(0));
    chk("reset_sat_cnt", 32'(sat_cnt), 32'(0));
    reset = 1'b0;

    // Single-step: three presses, pulse one clk after each press.
    for (int p = 0; p < 3; p++) begin
      step_pb = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("step_pulse", 32'(cpu_en), 32'(i == 0));
      end
      step_pb = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk("step_gap", 32'(cpu_en), 32'(0));
      end
    end
    @(negedge clk);
    chk("step_retired", 32'(retired_cnt), 32'(3));
    chk("step_pc", 32'(pc), 32'(3));
    chk("step_state", 32'(state_o), 32'(0));

    // Free run: run_sw wins over a simultaneous press; pulses every 4 clk.
    pulse_reset();
    run_sw  = 1'b1;
    step_pb = 1'b1;
    pulses  = 0;
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      if (n == 2) step_pb = 1'b0;
      if (n == 1) chk("run_beats_step", 32'(state_o), 32'(1));
      chk("run_pulse", 32'(cpu_en), 32'((n >= 5) && ((n - 5) % 4 == 0)));
      if (cpu_en) pulses++;
    end
    chk("run_pulse_count", 32'(pulses), 32'(10));
    chk("run_retired", 32'(retired_cnt), 32'(9));
    chk("run_pc", 32'(pc), 32'(9));

    // Reset while cpu_en is high clears outputs without waiting for a clock.
    reset = 1'b1;
    #1;
    chk("rst_mid_cpu_en", 32'(cpu_en), 32'(0));
    chk("rst_mid_state", 32'(state_o), 32'(0));
    chk("rst_mid_retired", 32'(retired_cnt), 32'(0));
    @(negedge clk);
    run_sw = 1'b0;
    reset  = 1'b0;

    // Breakpoint at pc 5: five retirements, then park in BREAK.
    bp_en   = 1'b1;
    bp_addr = 9'h005;
    run_sw  = 1'b1;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      chk("bp_run_pulse", 32'(cpu_en), 32'((n >= 5) && (n <= 21) && ((n - 5) % 4 == 0)));
    end
    chk("bp_state", 32'(state_o), 32'(2));
    chk("bp_pc", 32'(pc), 32'(5));
    chk("bp_retired", 32'(retired_cnt), 32'(5));

    // One press retires the breakpointed instruction and resumes RUN without re-breaking.
    step_pb = 1'b1;
    for (int m = 1; m <= 9; m++) begin
      @(negedge clk);
      if (m == 4) step_pb = 1'b0;
      if (m == 1) chk("bp_resume_state", 32'(state_o), 32'(1));
      if (m == 2) chk("bp_resume_pc", 32'(pc), 32'(6));
      chk("bp_resume_pulse", 32'(cpu_en), 32'((m == 1) || (m == 5) || (m == 9)));
    end
    chk("bp_still_run", 32'(state_o), 32'(1));

    // Dropping run_sw between ticks returns to IDLE on the next edge.
    run_sw = 1'b0;
    @(negedge clk);
    chk("run_off_state", 32'(state_o), 32'(0));
    chk("run_off_cpu_en", 32'(cpu_en), 32'(0));
    bp_en = 1'b0;

    // Halt at pc 3: three retirements, then DONE is sticky.
    pulse_reset();
    halt_pc  = 9'h003;
    halt_arm = 1'b1;
    run_sw   = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk("halt_run_pulse", 32'(cpu_en), 32'((n >= 5) && (n <= 13) && ((n - 5) % 4 == 0)));
    end
    chk("halt_state", 32'(state_o), 32'(3));
    chk("halt_retired", 32'(retired_cnt), 32'(3));
    for (int i = 0; i < 12; i++) begin
      step_pb = 1'((i / 2) % 2);
      run_sw  = 1'((i / 4) % 2);
      @(negedge clk);
      chk("done_no_pulse", 32'(cpu_en), 32'(0));
      chk("done_sticky", 32'(state_o), 32'(3));
    end
    chk("done_retired", 32'(retired_cnt), 32'(3));
    step_pb  = 1'b0;
    run_sw   = 1'b0;
    halt_arm = 1'b0;

    // Saturation: RATE_DIV=1, 4-bit counter pinned at 15.
    pulse_reset();
    sat_run = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) chk("sat_first_cpu_en", 32'(sat_cpu_en), 32'(0));
      if (n == 10) chk("sat_cnt_mid", 32'(sat_cnt), 32'(8));
      if (n >= 17) chk("sat_cnt_hold", 32'(sat_cnt), 32'(15));
    end
    chk("sat_cpu_en_cont", 32'(sat_cpu_en), 32'(1));
    chk("sat_state", 32'(sat_state), 32'(1));
    sat_run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
